rom_rd_arbiter: RTL
===================

ROM_RD_ARBITER -- requirements
Module: rom_rd_arbiter

Interface
REQ-001 Parameter AW, default 10, ROM address width (1024 words).
REQ-002 Parameter DW, default 8, ROM data width.
REQ-003 Parameter LW, default 4, burst length field width; beats = len+1, max 16.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req0 / req1  input  1  read request from requester 0 / 1; held high until its gnt is seen.
REQ-007 addr0 / addr1  input  AW  burst start address; stable while req high.
REQ-008 len0 / len1  input  LW  burst length minus one; stable while req high.
REQ-009 gnt0 / gnt1  output  1  one-cycle grant pulse to requester 0 / 1.
REQ-010 rom_addr  output  AW  address to the synchronous ROM; the ROM returns data one cycle later.
REQ-011 rom_data  input  DW  registered ROM read data.
REQ-012 rd_data  output  DW  read data to requesters; direct pass-through of rom_data.
REQ-013 rd_valid  output  1  rd_data carries a valid beat this cycle.
REQ-014 rd_id  output  1  owner of the current beat (0 or 1).
REQ-015 rd_last  output  1  final beat of the burst; qualified by rd_valid.
REQ-016 busy  output  1  high in BURST and DRAIN.

Function
REQ-017 FSM states: IDLE, BURST, DRAIN.
REQ-018 In IDLE at cycle T, with any req high, the block latches the winner's id, address and length, and enters BURST at T+1.
REQ-019 The winner's gnt is high for exactly cycle T+1; the loser's gnt stays low and its request remains pending.
REQ-020 In BURST, rom_addr = start + beat for beat 0..len, one beat per cycle; cycles T+1..T+len+1.
REQ-021 Address arithmetic is modulo 2^AW: 1023+1 wraps to 0.
REQ-022 rd_valid is high exactly one cycle after each issued address (T+2..T+len+2); rd_id equals the latched owner.
REQ-023 rd_last is high with the beat of index len; for len=0, rd_valid and rd_last coincide at T+2.
REQ-024 After the last address, BURST goes to DRAIN for one cycle (last beat returns), then to IDLE; the next arbitration occurs no earlier than T+len+3.
REQ-025 In IDLE and DRAIN, rom_addr holds its last driven value.
REQ-026 Requests arriving during BURST/DRAIN are not sampled until IDLE.
REQ-027 A single requesting port always wins regardless of priority state.
REQ-028 No output is combinationally dependent on req/addr/len; rd_data alone is combinational, from rom_data.

Reset
REQ-029 With rst high at a rising edge, next cycle: state IDLE, gnt0=gnt1=0, rd_valid=0, rd_last=0, rd_id=0, busy=0, rom_addr=0, beat counter=0, priority pointer favours port 0.
REQ-030 Reset mid-burst aborts the burst: no rd_valid in any cycle after the reset edge; no grant is issued while rst is high.

Configuration
REQ-031 Macro ROM_ARB_RR_EN defined: round-robin; when both request, the port not granted last wins; the pointer updates on every grant.
REQ-032 ROM_ARB_RR_EN undefined: fixed priority; port 0 always wins a tie; no pointer state exists.

Verification
REQ-033 rst for 2 cycles, then release -> all outputs 0, busy=0, rom_addr=0.
REQ-034 req0 alone, addr0=0x010, len0=3 -> gnt0 one cycle; rom_addr 0x010..0x013; four rd_valid beats, rd_id=0, rd_last on the 4th; busy for 5 cycles.
REQ-035 req1 alone, addr1=0x3FE, len1=2 -> rom_addr 0x3FE, 0x3FF, 0x000; rd_data matches ROM contents at those addresses.
REQ-036 req0 and req1 held continuously, both len=0 -> with ROM_ARB_RR_EN grants alternate 0,1,0,1; without it, port 0 is granted every time.
REQ-037 req0, addr0=0x100, len0=15; assert rst for one cycle at the 5th beat -> rd_valid low from the next cycle, state IDLE, a pending req1 is granted after rst falls.
REQ-038 req1 raised during port 0's BURST -> gnt1 not before port 0's DRAIN has completed; no overlap of rd_id values.

Source files
------------

// File: rtl/rom_rd_arbiter.sv
// Two-port burst read arbiter in front of a synchronous (1-cycle latency) ROM.
// Define ROM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
module rom_rd_arbiter #(
   parameter int AW = 10,
   parameter int DW = 8,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [LW-1:0] len0,
   input  logic [LW-1:0] len1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          rd_id,
   output logic          rd_last,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   state_t        state_reg;
   logic          owner_reg;
   logic [LW-1:0] len_reg;
   logic [LW-1:0] beat_reg;
   logic          win;
`ifdef ROM_ARB_RR_EN
   logic          prio_reg;   // 1: port 1 is favoured on a tie
`endif

   always_comb begin
      win = req1 & ~req0;
`ifdef ROM_ARB_RR_EN
      if (req0 & req1) win = prio_reg;
`endif
   end

   assign rd_data = rom_data;
   assign busy    = (state_reg != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         owner_reg <= 1'b0;
         len_reg   <= '0;
         beat_reg  <= '0;
         rom_addr  <= '0;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_id     <= 1'b0;
`ifdef ROM_ARB_RR_EN
         prio_reg  <= 1'b0;
`endif
      end else begin
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req0 | req1) begin
                  owner_reg <= win;
                  len_reg   <= win ? len1 : len0;
                  rom_addr  <= win ? addr1 : addr0;
                  beat_reg  <= '0;
                  gnt0      <= ~win;
                  gnt1      <= win;
                  state_reg <= BURST;
`ifdef ROM_ARB_RR_EN
                  prio_reg  <= ~win;
`endif
               end
            end
            BURST: begin
               // The beat addressed now returns from the ROM next cycle.
               rd_valid <= 1'b1;
               rd_id    <= owner_reg;
               rd_last  <= (beat_reg == len_reg);
               if (beat_reg == len_reg) begin
                  state_reg <= DRAIN;
               end else begin
                  beat_reg <= beat_reg + LW'(1);
                  rom_addr <= rom_addr + AW'(1);
               end
            end
            DRAIN: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
